// File: rtl/axi_lite_to_mem.sv
// AXI4-Lite slave bridging single-beat reads and writes onto a req/gnt/rvalid memory port.
// One transaction in flight; reads and writes alternate priority when both are pending.
module axi_lite_to_mem #(
  parameter  int unsigned AddrWidth = 32,
  parameter  int unsigned DataWidth = 32,
  localparam int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // write address / data / response
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [DataWidth-1:0] w_data_i,
  input  logic [StrbWidth-1:0] w_strb_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  // read address / data
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  // memory side
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [StrbWidth-1:0] mem_be_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_err_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e               state_q;
  logic                 prio_wr_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [StrbWidth-1:0] be_q;
  logic                 we_q;
  logic                 req_q;
  logic                 b_valid_q;
  logic [1:0]           b_resp_q;
  logic                 r_valid_q;
  logic [1:0]           r_resp_q;
  logic [DataWidth-1:0] r_data_q;

  logic                 in_idle;
  logic                 wr_elig;
  logic                 rd_elig;
  logic                 sel_wr;
  logic                 sel_rd;
  logic [StrbWidth-1:0] acc_be_d;
  logic [1:0]           resp_d;

  // Readies are gated by reset so nothing is accepted while rst_ni is low.
  assign in_idle = rst_ni && (state_q == IDLE);
  assign wr_elig = aw_valid_i && w_valid_i;
  assign rd_elig = ar_valid_i;
  assign sel_wr  = in_idle && wr_elig && (!rd_elig || prio_wr_q);
  assign sel_rd  = in_idle && rd_elig && (!wr_elig || !prio_wr_q);

  assign aw_ready_o = sel_wr;
  assign w_ready_o  = sel_wr;
  assign ar_ready_o = sel_rd;

  // Reads always enable every byte lane; writes pass the strobes through unchanged.
  for (genvar gi = 0; gi < StrbWidth; gi++) begin : g_acc_be
    assign acc_be_d[gi] = sel_rd | w_strb_i[gi];
  end

  assign resp_d = mem_err_i ? RespSlvErr : RespOkay;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      prio_wr_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      r_valid_q <= 1'b0;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_wr || sel_rd) begin
            addr_q    <= sel_wr ? aw_addr_i : ar_addr_i;
            be_q      <= acc_be_d;
            we_q      <= sel_wr;
            req_q     <= 1'b1;
            prio_wr_q <= sel_rd;
            state_q   <= REQ;
            if (sel_wr) begin
              wdata_q <= w_data_i;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (we_q) begin
              b_resp_q  <= resp_d;
              b_valid_q <= 1'b1;
            end else begin
              r_data_q  <= mem_rdata_i;
              r_resp_q  <= resp_d;
              r_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if ((b_valid_q && b_ready_i) || (r_valid_q && r_ready_i)) begin
            b_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

  assign b_valid_o = b_valid_q;
  assign b_resp_o  = b_resp_q;
  assign r_valid_o = r_valid_q;
  assign r_resp_o  = r_resp_q;
  assign r_data_o  = r_data_q;

endmodule

// File: doc/axi_lite_to_mem.md
Name: axi_lite_to_mem

Overview:
- AXI4-Lite slave that converts single-beat AXI-Lite reads and writes into a request/grant/valid memory interface (SRAM or register file).
- Sits directly downstream of the AXI-to-AXI-Lite converter chain and consumes its AXI-Lite master port.
- Serves one transaction at a time.
- Arbitrates reads against writes with alternating priority.

Parameters:
- AddrWidth, 32, width of AXI-Lite and memory addresses.
- DataWidth, 32, data width in bits. Must be a multiple of 8. StrbWidth = DataWidth/8 is derived, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_addr_i  in  AddrWidth  write address
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- w_data_i  in  DataWidth  write data
- w_strb_i  in  StrbWidth  write byte strobes
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- b_resp_o  out  2  write response
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- ar_addr_i  in  AddrWidth  read address
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- r_data_o  out  DataWidth  read data
- r_resp_o  out  2  read response
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  AddrWidth  memory address
- mem_we_o  out  1  1 = write, 0 = read
- mem_be_o  out  StrbWidth  byte enables
- mem_wdata_o  out  DataWidth  memory write data
- mem_rvalid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  DataWidth  memory read data
- mem_err_i  in  1  error, sampled with mem_rvalid_i

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all ready/valid/req outputs 0; resp, data, addr, be and wdata outputs 0; priority bit = write.
- FSM states and transitions:
  - IDLE: a write is eligible when aw_valid_i and w_valid_i are both high; a read is eligible when ar_valid_i is high. AW without W, or W without AW, is never accepted alone.
  - IDLE selection: with one eligible kind, select it. With both eligible, select the kind holding priority.
  - IDLE handshake: on the selected kind, assert the matching ready(s) combinationally in that cycle (aw_ready_o and w_ready_o together, or ar_ready_o). Latch addr, wdata, strb and we. Go to REQ. The other kind's ready stays 0.
  - REQ: mem_req_o=1; mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o come from the latched values. On mem_gnt_i, go to WAIT. For reads, mem_be_o is all ones.
  - WAIT: mem_req_o=0. On mem_rvalid_i, capture mem_rdata_i (reads only) and resp (mem_err_i ? 2'b10 SLVERR : 2'b00 OKAY). Go to RESP. mem_rvalid_i may arrive in the cycle right after the grant.
  - RESP: b_valid_o=1 for writes, or r_valid_o=1 for reads. Outputs hold stable until b_ready_i or r_ready_i respectively. On handshake, go to IDLE.
- Priority: updated when a transaction is accepted in IDLE. After a write, reads gain priority; after a read, writes gain priority. A non-tie acceptance also updates it.
- Minimum latency: accept in cycle 0, req in cycle 1, gnt in cycle 1, rvalid in cycle 2, b/r valid in cycle 3. The next accept can happen in the cycle after the response handshake.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside REQ is ignored.
- A write with w_strb_i=0 is still issued, with mem_be_o=0.
- r_data_o is undefined-free: it holds the last captured read data. b_resp_o and r_resp_o hold their last value while the matching valid is low.
- Reset mid-transaction drops the transaction with no response. Inputs are not sampled while rst_ni is low.

Test Plan:
- Write addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF; gnt in the req cycle, rvalid next cycle, err=0 -> mem_we_o=1, mem_be_o=4'hF, b_valid_o rises 3 cycles after accept, b_resp_o=2'b00.
- Read addr 0x20; mem returns 0x1234_5678 with err=1 after a 2-cycle gnt stall -> mem_req_o held for 3 cycles, r_data_o=0x1234_5678, r_resp_o=2'b10.
- AW and W valid together with AR valid from reset, repeated 4 times -> service order W, R, W, R.
- aw_valid_i high and w_valid_i low for 5 cycles, then w_valid_i rises -> aw_ready_o stays 0 until w_valid_i is high; single accept cycle with aw_ready_o=w_ready_o=1.
- r_ready_i held low for 4 cycles in RESP -> r_valid_o and r_data_o stable; ar_ready_o=0 for a pending AR until after the handshake.
- rst_ni pulsed low in WAIT -> all outputs 0 immediately; a later mem_rvalid_i produces no b_valid_o.
